// File: rtl/probe_buffer_mc.sv
// probe_buffer_mc: multi-channel taint-tracking probe FIFO.
// Round-robin producers share one FIFO drained by a valid/ready consumer.
module probe_buffer_mc #(
    parameter int                NCH        = 2,
    parameter int                DATA_W     = 64,
    parameter int                DEPTH      = 8,
    parameter logic [DATA_W-1:0] SECRET_CMD = 64'hAF1B_608E_883D_0000,
    localparam int               AW         = $clog2(DEPTH),
    localparam int               CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH-1:0]        wen,
    output logic [NCH-1:0]        wready,
    input  logic [NCH*DATA_W-1:0] write,
    input  logic [NCH*DATA_W-1:0] write_taint_0,
    output logic                  read_valid,
    input  logic                  read_ready,
    output logic [DATA_W-1:0]     read,
    output logic [DATA_W-1:0]     read_taint_0,
    output logic [CW-1:0]         read_chan,
    output logic                  read_secret,
    output logic [AW:0]           count,
    output logic [31:0]           taint_sum,
    output logic [31:0]           stall_cnt
);

    logic [DATA_W-1:0] mem_data   [DEPTH];
    logic [DATA_W-1:0] mem_taint  [DEPTH];
    logic [CW-1:0]     mem_chan   [DEPTH];
    logic [DEPTH-1:0]  mem_secret;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     rr_next;
    logic [CW-1:0]     gnt_idx;
    logic              gnt_valid;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] sel_taint;
    logic [DATA_W-1:0] st_taint;
    logic              st_secret;
    logic              st_tainted;
    logic              head_tainted;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = gnt_valid && !full;
    assign pop   = !empty && read_ready;

    // Round-robin scan: first requester at or above rr_ptr, wrapping.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!gnt_valid && wen[(int'(rr_ptr) + k) % NCH]) begin
                gnt_valid = 1'b1;
                gnt_idx   = CW'((int'(rr_ptr) + k) % NCH);
            end
        end
    end

    // Accept strobes: only the granted channel, never while full.
    always_comb begin
        wready = '0;
        if (!full) begin
            if (NCH == 1) begin
                wready = '1;
            end else if (gnt_valid) begin
                wready[gnt_idx] = 1'b1;
            end
        end
    end

    // Ingress entry build; the secret command is stored fully tainted.
    always_comb begin
        sel_data   = write[int'(gnt_idx)*DATA_W +: DATA_W];
        sel_taint  = write_taint_0[int'(gnt_idx)*DATA_W +: DATA_W];
        st_secret  = (sel_data == SECRET_CMD);
        st_taint   = st_secret ? '1 : sel_taint;
        st_tainted = |st_taint;
        rr_next    = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + CW'(1);
    end

    // Storage array; contents are only observable while count covers them.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr]   <= sel_data;
            mem_taint[wr_ptr]  <= st_taint;
            mem_chan[wr_ptr]   <= gnt_idx;
            mem_secret[wr_ptr] <= st_secret;
        end
    end

    // Pointers, occupancy and round-robin state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rr_ptr <= rr_next;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (!push && pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    assign head_tainted = |mem_taint[rd_ptr];

    // Tainted-entry tally tracks pushes and pops of tainted entries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            taint_sum <= '0;
        end else begin
            if ((push && st_tainted) && !(pop && head_tainted)) begin
                taint_sum <= taint_sum + 32'd1;
            end else if (!(push && st_tainted) && (pop && head_tainted)) begin
                taint_sum <= taint_sum - 32'd1;
            end
        end
    end

    // Saturating count of cycles where someone asked and nobody got in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if ((|wen) && !push && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // Head view, forced to zero while empty.
    always_comb begin
        read_valid   = !empty;
        read         = empty ? '0 : mem_data[rd_ptr];
        read_taint_0 = empty ? '0 : mem_taint[rd_ptr];
        read_chan    = empty ? '0 : mem_chan[rd_ptr];
        read_secret  = empty ? 1'b0 : mem_secret[rd_ptr];
    end

endmodule

// File: tb/tb_probe_buffer_mc.sv
// tb_probe_buffer_mc: directed checks for probe_buffer_mc.
// Two channels, depth 8, default secret command.
module tb_probe_buffer_mc;

    localparam logic [63:0] SECRET = 64'hAF1B_608E_883D_0000;

    logic         clock;
    logic         reset;
    logic [1:0]   wen;
    logic [1:0]   wready;
    logic [127:0] write;
    logic [127:0] write_taint_0;
    logic         read_valid;
    logic         read_ready;
    logic [63:0]  read;
    logic [63:0]  read_taint_0;
    logic [0:0]   read_chan;
    logic         read_secret;
    logic [3:0]   count;
    logic [31:0]  taint_sum;
    logic [31:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    probe_buffer_mc dut (
        .clock        (clock),
        .reset        (reset),
        .wen          (wen),
        .wready       (wready),
        .write        (write),
        .write_taint_0(write_taint_0),
        .read_valid   (read_valid),
        .read_ready   (read_ready),
        .read         (read),
        .read_taint_0 (read_taint_0),
        .read_chan    (read_chan),
        .read_secret  (read_secret),
        .count        (count),
        .taint_sum    (taint_sum),
        .stall_cnt    (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [63:0] d,
                          input logic [63:0] t);
        write[ch*64 +: 64]         = d;
        write_taint_0[ch*64 +: 64] = t;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wen = 2'bxx;
        read_ready = 1'b0;
        write = '0;
        write_taint_0 = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (count !== 4'd0 || read_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_count: count=%0d valid=%b want 0 0",
                     count, read_valid);
        end
        checks++;
        if (taint_sum !== 32'd0 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_ctrs: taint_sum=%0d stall=%0d want 0 0",
                     taint_sum, stall_cnt);
        end
        checks++;
        if (read !== 64'd0 || read_taint_0 !== 64'd0 ||
            read_chan !== 1'b0 || read_secret !== 1'b0) begin
            errors++;
            $display("FAIL reset_head: read=%h taint=%h chan=%b sec=%b want 0",
                     read, read_taint_0, read_chan, read_secret);
        end
        wen = 2'b00;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        set_ch(0, 64'h1234, 64'h0);
        wen = 2'b01;
        #1;
        checks++;
        if (wready !== 2'b01) begin
            errors++;
            $display("FAIL single_wready: got %b want 01", wready);
        end
        tick();
        wen = 2'b00;
        checks++;
        if (read_valid !== 1'b1 || read !== 64'h1234 ||
            read_taint_0 !== 64'h0 || read_chan !== 1'b0 ||
            read_secret !== 1'b0) begin
            errors++;
            $display("FAIL single_head: v=%b read=%h taint=%h chan=%b sec=%b want 1 1234 0 0 0",
                     read_valid, read, read_taint_0, read_chan, read_secret);
        end
        checks++;
        if (count !== 4'd1 || taint_sum !== 32'd0) begin
            errors++;
            $display("FAIL single_count: count=%0d taint_sum=%0d want 1 0",
                     count, taint_sum);
        end
        read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
        checks++;
        if (count !== 4'd0 || read_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: count=%0d valid=%b want 0 0",
                     count, read_valid);
        end
    endtask

    task automatic test_secret();
        set_ch(1, SECRET, 64'h0);
        wen = 2'b10;
        tick();
        wen = 2'b00;
        checks++;
        if (read_taint_0 !== {64{1'b1}} || read_secret !== 1'b1 ||
            read_chan !== 1'b1 || read !== SECRET) begin
            errors++;
            $display("FAIL secret_head: read=%h taint=%h sec=%b chan=%b want secret/all-ones/1/1",
                     read, read_taint_0, read_secret, read_chan);
        end
        checks++;
        if (taint_sum !== 32'd1) begin
            errors++;
            $display("FAIL secret_tsum: got %0d want 1", taint_sum);
        end
        read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
        checks++;
        if (taint_sum !== 32'd0 || read_valid !== 1'b0) begin
            errors++;
            $display("FAIL secret_pop: taint_sum=%0d valid=%b want 0 0",
                     taint_sum, read_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_w;
        set_ch(0, 64'hA0, 64'h0);
        set_ch(1, 64'hA1, 64'h0);
        wen = 2'b11;
        read_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_w = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (wready !== exp_w) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b want %b", k, wready, exp_w);
            end
            if (k > 0) begin
                checks++;
                if (read_valid !== 1'b1 || read_chan !== 1'((k - 1) % 2)) begin
                    errors++;
                    $display("FAIL rr_chan%0d: v=%b chan=%b want 1 %0d",
                             k, read_valid, read_chan, (k - 1) % 2);
                end
            end
            tick();
        end
        wen = 2'b00;
        checks++;
        if (read_chan !== 1'b1 || read !== 64'hA1) begin
            errors++;
            $display("FAIL rr_last: chan=%b read=%h want 1 a1", read_chan, read);
        end
        tick();
        read_ready = 1'b0;
        checks++;
        if (stall_cnt !== 32'd0 || count !== 4'd0) begin
            errors++;
            $display("FAIL rr_stall: stall=%0d count=%0d want 0 0",
                     stall_cnt, count);
        end
    endtask

    task automatic test_full();
        logic [63:0] exp_q [8];
        read_ready = 1'b0;
        wen = 2'b01;
        for (int i = 0; i < 8; i++) begin
            set_ch(0, 64'(100 + i), 64'h0);
            tick();
        end
        set_ch(0, 64'd200, 64'h0);
        checks++;
        if (count !== 4'd8 || wready !== 2'b00) begin
            errors++;
            $display("FAIL full_state: count=%0d wready=%b want 8 00",
                     count, wready);
        end
        repeat (3) tick();
        checks++;
        if (stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL full_stall: got %0d want 3", stall_cnt);
        end
        read_ready = 1'b1;
        #1;
        checks++;
        if (wready !== 2'b00) begin
            errors++;
            $display("FAIL full_nopass: wready=%b want 00", wready);
        end
        tick();
        read_ready = 1'b0;
        checks++;
        if (count !== 4'd7 || wready !== 2'b01) begin
            errors++;
            $display("FAIL full_poponly: count=%0d wready=%b want 7 01",
                     count, wready);
        end
        tick();
        wen = 2'b00;
        checks++;
        if (count !== 4'd8 || stall_cnt !== 32'd4) begin
            errors++;
            $display("FAIL full_refill: count=%0d stall=%0d want 8 4",
                     count, stall_cnt);
        end
        for (int i = 0; i < 7; i++) exp_q[i] = 64'(101 + i);
        exp_q[7] = 64'd200;
        read_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (read_valid !== 1'b1 || read !== exp_q[i]) begin
                errors++;
                $display("FAIL full_drain%0d: v=%b read=%0d want 1 %0d",
                         i, read_valid, read, exp_q[i]);
            end
            tick();
        end
        read_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [63:0] got [$];
        int n = 0;
        int guard = 0;
        int bad = 0;
        while ((n < 20 || count != 4'd0) && guard < 500) begin
            if (n < 20) begin
                wen = 2'b01;
                set_ch(0, 64'(n), 64'h0);
                read_ready = 1'($urandom_range(0, 1));
            end else begin
                wen = 2'b00;
                read_ready = 1'b1;
            end
            #1;
            if (read_valid && read_ready) got.push_back(read);
            if (wen[0] && wready[0]) n++;
            tick();
            guard++;
        end
        wen = 2'b00;
        read_ready = 1'b0;
        checks++;
        if (guard >= 500) begin
            errors++;
            $display("FAIL wrap_timeout: pushed=%0d count=%0d", n, count);
        end
        checks++;
        if (got.size() != 20) begin
            errors++;
            $display("FAIL wrap_size: got %0d want 20", got.size());
        end
        foreach (got[i]) if (got[i] !== 64'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap_order: %0d out-of-order words want 0", bad);
        end
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_empty: count=%0d want 0", count);
        end
    endtask

    task automatic test_async_reset();
        read_ready = 1'b0;
        wen = 2'b01;
        for (int i = 0; i < 5; i++) begin
            set_ch(0, 64'(300 + i), (i % 2 == 0) ? 64'(1 << i) : 64'h0);
            tick();
        end
        wen = 2'b00;
        checks++;
        if (count !== 4'd5 || taint_sum !== 32'd3) begin
            errors++;
            $display("FAIL arst_pre: count=%0d taint_sum=%0d want 5 3",
                     count, taint_sum);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || taint_sum !== 32'd0 || read_valid !== 1'b0 ||
            read !== 64'd0) begin
            errors++;
            $display("FAIL arst_now: count=%0d taint_sum=%0d v=%b read=%h want 0 0 0 0",
                     count, taint_sum, read_valid, read);
        end
        reset = 1'b1;
        set_ch(0, 64'hAAA, 64'h0);
        set_ch(1, 64'hBBB, 64'h0);
        wen = 2'b11;
        #1;
        checks++;
        if (wready !== 2'b01) begin
            errors++;
            $display("FAIL arst_rr: wready=%b want 01", wready);
        end
        tick();
        wen = 2'b00;
        checks++;
        if (count !== 4'd1 || read_chan !== 1'b0 || read !== 64'hAAA) begin
            errors++;
            $display("FAIL arst_first: count=%0d chan=%b read=%h want 1 0 aaa",
                     count, read_chan, read);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_secret();
        test_round_robin();
        test_full();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
